dr_token_fifo: RTL and testbench
================================

// Module: dr_token_fifo
// PURPOSE
//  Clocked, parametrised dual-rail token buffer: DEPTH-entry FIFO with dual-rail+ack links on both sides.
//  Supports two-phase (TP) or four-phase (FP) handshakes and pre-loaded reset tokens.
//  Sits between clocked logic and dual-rail pipelines, or forms the initialised stage of a token ring.
// PARAMETERS
//  ENC     "TP"  link encoding: "TP" = two-phase transition, "FP" = four-phase return-to-null
//  WIDTH   8     data bits per token (each bit = 2 rails, [1]=true rail, [0]=false rail)
//  DEPTH   4     FIFO entries, >=2
//  N_INIT  0     tokens present after reset, 0..DEPTH
//  INIT    '0    WIDTH-bit value of every pre-loaded token
// PORTS
//  clk     in   1           clock; all state updates on rising edge
//  rst     in   1           reset, synchronous, active-low
//  ack_o   out  1           input-link acknowledge
//  in      in   WIDTH x 2   input dual-rail token
//  ack_i   in   1           output-link acknowledge from consumer
//  out     out  WIDTH x 2   output dual-rail token (registered)
//  level   out  $clog2(DEPTH+1)  occupancy, registered
//  err     out  1           sticky protocol error (only with DR_TOKEN_FIFO_PROTO_CHECK_EN)
// BEHAVIOUR
//  Reset (rst==0 at edge): ack_o=0, out=all rails 0, phases=0, wr/rd ptr=0, level=N_INIT, err=0;
//   slots 0..N_INIT-1 hold INIT. Applies mid-operation; any in-flight token is discarded.
//  in/ack_i are sampled each edge; sources are clk-synchronous.
//  RX FP: READY (ack_o=0): on edge where every bit has exactly one rail high and level<DEPTH,
//   write decoded word, ack_o<=1, go CAPT. CAPT: when all rails 0, ack_o<=0, go READY.
//   Complete word while full: no write, ack_o stays 0, retried every cycle.
//  RX TP: prev_in register holds last accepted rails. Token complete when every bit has exactly
//   one rail differing from prev_in; value bit = in[i][1]^prev_in[i][1]. On complete and
//   level<DEPTH: write, prev_in<=in, ack_o toggles.
//  TX FP: IDLE: if level>0, out<=encode(head), go DATA. DATA: on ack_i==1, out<=null, pop, go
//   NULL. NULL: on ack_i==0, go IDLE. IDLE->DATA re-check is same edge as NULL exit (no bubble).
//  TX TP: IDLE: if level>0, toggle rail (value?1:0) of each bit, go WAIT.
//   WAIT: on ack_i != tx_phase, pop, tx_phase flips, go IDLE.
//  Latency: complete input sampled at edge N -> ack_o and write at N; earliest out change at N+1.
//  Simultaneous push and pop: both take effect; level unchanged. Push is gated by level<DEPTH
//   as registered at the start of the cycle: no push on a full FIFO even with a same-cycle pop.
//  Pointers wrap modulo DEPTH (non-power-of-2 handled by explicit compare).
//  N_INIT>0: first token presented at first edge after rst deasserts.
// CONFIGURATION
//  DR_TOKEN_FIFO_PROTO_CHECK_EN defined: err port present; err sticky-set on
//   - FP: a bit with both rails high;
//   - TP: a bit with both rails changed vs prev_in;
//   - FP: partial null in CAPT (some bit changes data->other rail).
//   Cleared only by reset.
//  Not defined: no err port, no check logic; illegal codes are simply treated as incomplete.
// STRUCTURE
//  Package dr_pkg: RAIL_NUM=2, enc_e {ENC_TP, ENC_FP}, functions dr_complete_fp, dr_null,
//   dr_complete_tp, dr_decode, dr_encode_fp. Shared with other dual-rail blocks.
//  Sub-module dr_link_rx: completion detection, decode, prev_in and ack_o generation.
//   Storage and TX FSM stay in the top.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  FP single token 0xA5, ack_i tied to out-valid after 2 cycles:
//   ack_o rises 1 edge after in complete; out=enc(0xA5) next edge; nulls propagate; level 1->0.
//  FP fill, ack_i=0: offer 5 tokens 0x01..0x05 -> 4 acked, level=4, 5th unacked;
//   one consumer handshake -> 0x05 accepted, out order 01,02,03,04,05.
//  TP stream 0x00,0xFF,0x3C,0xC3 with random 0-5 cycle ack_i delay
//   -> ack_o toggles 4 times, out tokens same order/values.
//  N_INIT=2, INIT=0x5A -> out=enc(0x5A) first edge after reset, second 0x5A after first ack_i, then empty.
//  FP partial: 7 of 8 bits valid for 10 cycles -> no ack_o; 8th bit valid -> ack_o next edge.
//  Reset asserted with level=3 mid-handshake -> next edge ack_o=0, out null, level=N_INIT;
//   with PROTO_CHECK_EN, bit 0 both rails high -> err=1 and stays 1 until reset.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared dual-rail link definitions: rail pair type, link encodings and per-bit helpers.
// Used by dr_token_fifo and other dual-rail blocks.
package dr_pkg;

  localparam int unsigned RAIL_NUM = 2;

  // [1] = true rail, [0] = false rail
  typedef logic [RAIL_NUM-1:0] dr_bit_t;

  typedef enum logic {ENC_TP, ENC_FP} enc_e;

  function automatic logic dr_complete_fp(input dr_bit_t r);
    return (r == 2'b01) || (r == 2'b10);
  endfunction

  function automatic logic dr_null(input dr_bit_t r);
    return r == 2'b00;
  endfunction

  function automatic logic dr_complete_tp(input dr_bit_t r, input dr_bit_t prev);
    return dr_complete_fp(r ^ prev);
  endfunction

  function automatic logic dr_decode(input dr_bit_t r);
    return r[1];
  endfunction

  function automatic dr_bit_t dr_encode_fp(input logic v);
    return {v, ~v};
  endfunction

endpackage

// File: rtl/dr_link_rx.sv
// Dual-rail receive link: completion detection, decode, prev_in tracking and ack_o generation.
// DR_TOKEN_FIFO_PROTO_CHECK_EN adds the sticky protocol-error output err.
module dr_link_rx
  import dr_pkg::*;
#(
  parameter enc_e        ENC   = ENC_TP,
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  dr_bit_t [WIDTH-1:0] in,
  input  logic                full,
  output logic                wr_en,
  output logic [WIDTH-1:0]    wr_data,
  output logic                ack_o
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
  ,
  output logic                err
`endif
);

  typedef enum logic {RX_READY, RX_CAPT} rx_state_e;

  rx_state_e           state_q, state_d;
  dr_bit_t [WIDTH-1:0] prev_in_q, prev_in_d;
  logic                tp_ack_q, tp_ack_d;
  logic                all_fp, all_null, all_tp;

  always_comb begin
    all_fp   = 1'b1;
    all_null = 1'b1;
    all_tp   = 1'b1;
    wr_data  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      all_fp     &= dr_complete_fp(in[i]);
      all_null   &= dr_null(in[i]);
      all_tp     &= dr_complete_tp(in[i], prev_in_q[i]);
      wr_data[i]  = (ENC == ENC_FP) ? dr_decode(in[i]) : dr_decode(in[i] ^ prev_in_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RX_READY;
      prev_in_q <= '0;
      tp_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_in_q <= prev_in_d;
      tp_ack_q  <= tp_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_in_d = prev_in_q;
    tp_ack_d  = tp_ack_q;
    if (wr_en) begin
      prev_in_d = in;
      tp_ack_d  = ~tp_ack_q;
    end
    if (ENC == ENC_FP) begin
      unique case (state_q)
        RX_READY: if (wr_en) state_d = RX_CAPT;
        RX_CAPT:  if (all_null) state_d = RX_READY;
        default:  state_d = RX_READY;
      endcase
    end
  end

  always_comb begin
    if (ENC == ENC_FP) begin
      wr_en = (state_q == RX_READY) && all_fp && !full;
      ack_o = (state_q == RX_CAPT);
    end else begin
      wr_en = all_tp && !full;
      ack_o = tp_ack_q;
    end
  end

`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
  logic err_q, err_d, viol;

  always_comb begin
    viol = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ENC == ENC_FP) begin
        if (in[i] == 2'b11) viol = 1'b1;
        // Returning to null must not pass through the opposite data rail.
        if ((state_q == RX_CAPT) && dr_complete_fp(in[i]) && (in[i] != prev_in_q[i])) viol = 1'b1;
      end else if ((in[i] ^ prev_in_q[i]) == 2'b11) begin
        viol = 1'b1;
      end
    end
    err_d = err_q | viol;
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: rtl/dr_token_fifo.sv
// Dual-rail token FIFO: DEPTH-entry store between a dual-rail receive link and a TP/FP transmit FSM.
// Define DR_TOKEN_FIFO_PROTO_CHECK_EN to add the sticky protocol-error output err.
module dr_token_fifo
  import dr_pkg::*;
#(
  parameter enc_e             ENC    = ENC_TP,
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      DEPTH  = 4,
  parameter int unsigned      N_INIT = 0,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ack_o,
  input  dr_bit_t [WIDTH-1:0]        in,
  input  logic                       ack_i,
  output dr_bit_t [WIDTH-1:0]        out,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
  ,
  output logic                       err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_NULL} tx_state_e;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  tx_state_e           tx_state_q, tx_state_d;
  logic                tx_phase_q, tx_phase_d;
  dr_bit_t [WIDTH-1:0] out_q, out_d, tx_token;
  logic                push, pop, full, tx_ack, have_tok;
  logic [WIDTH-1:0]    wr_data, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  dr_link_rx #(
    .ENC   (ENC),
    .WIDTH (WIDTH)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .full    (full),
    .wr_en   (push),
    .wr_data (wr_data),
    .ack_o   (ack_o)
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
    ,
    .err     (err)
`endif
  );

  assign full     = (level_q == LVL_W'(DEPTH));
  assign have_tok = (level_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign tx_ack   = (ENC == ENC_FP) ? ack_i : (ack_i != tx_phase_q);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tx_token[i] = (ENC == ENC_FP) ? dr_encode_fp(head[i])
                                    : (out_q[i] ^ (head[i] ? 2'b10 : 2'b01));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= (i < N_INIT) ? INIT : '0;
      // Write pointer starts past the pre-loaded slots so the first push cannot overwrite them.
      wr_ptr_q   <= PTR_W'(N_INIT % DEPTH);
      rd_ptr_q   <= '0;
      level_q    <= LVL_W'(N_INIT);
      tx_state_q <= TX_IDLE;
      tx_phase_q <= 1'b0;
      out_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_state_q <= tx_state_d;
      tx_phase_q <= tx_phase_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE: if (have_tok) tx_state_d = TX_DATA;
      TX_DATA: if (tx_ack) tx_state_d = (ENC == ENC_FP) ? TX_NULL : TX_IDLE;
      TX_NULL: if (!ack_i) tx_state_d = have_tok ? TX_DATA : TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    pop        = 1'b0;
    tx_phase_d = tx_phase_q;
    unique case (tx_state_q)
      TX_IDLE: if (have_tok) out_d = tx_token;
      TX_DATA: begin
        if (tx_ack) begin
          pop = 1'b1;
          if (ENC == ENC_FP) out_d = '0;
          else               tx_phase_d = ~tx_phase_q;
        end
      end
      TX_NULL: if (!ack_i && have_tok) out_d = tx_token;
      default: out_d = '0;
    endcase
  end

  assign out   = out_q;
  assign level = level_q;

endmodule

// File: tb/tb_dr_token_fifo.sv
// Directed self-checking bench for dr_token_fifo: FP, TP and pre-loaded FP instances.
// Build with DR_TOKEN_FIFO_PROTO_CHECK_EN to also exercise the err output.
module tb_dr_token_fifo;
  import dr_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = $clog2(D + 1);

  typedef logic [W-1:0][1:0] tok_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          fp_rst = 1'b0, fp_ack_i = 1'b0, fp_ack_o;
  tok_t          fp_in = '0, fp_out;
  logic [LW-1:0] fp_level;
  logic          tp_rst = 1'b0, tp_ack_i = 1'b0, tp_ack_o;
  tok_t          tp_in = '0, tp_out;
  logic [LW-1:0] tp_level;
  logic          ini_rst = 1'b0, ini_ack_i = 1'b0, ini_ack_o;
  tok_t          ini_in = '0, ini_out;
  logic [LW-1:0] ini_level;
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
  logic          fp_err, tp_err, ini_err;
`endif

  int n_checks   = 0;
  int n_fail     = 0;
  int tp_toggles = 0;
  logic [W-1:0] tp_vals [4] = '{8'h00, 8'hFF, 8'h3C, 8'hC3};

  dr_token_fifo #(.ENC(ENC_FP), .WIDTH(W), .DEPTH(D), .N_INIT(0), .INIT(8'h00)) u_fp (
    .clk(clk), .rst(fp_rst), .ack_o(fp_ack_o), .in(fp_in), .ack_i(fp_ack_i), .out(fp_out),
    .level(fp_level)
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
    , .err(fp_err)
`endif
  );

  dr_token_fifo #(.ENC(ENC_TP), .WIDTH(W), .DEPTH(D), .N_INIT(0), .INIT(8'h00)) u_tp (
    .clk(clk), .rst(tp_rst), .ack_o(tp_ack_o), .in(tp_in), .ack_i(tp_ack_i), .out(tp_out),
    .level(tp_level)
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
    , .err(tp_err)
`endif
  );

  dr_token_fifo #(.ENC(ENC_FP), .WIDTH(W), .DEPTH(D), .N_INIT(2), .INIT(8'h5A)) u_init (
    .clk(clk), .rst(ini_rst), .ack_o(ini_ack_o), .in(ini_in), .ack_i(ini_ack_i), .out(ini_out),
    .level(ini_level)
`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
    , .err(ini_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-bit rail selection: true rail for 1, false rail for 0 (FP code and TP flip mask).
  function automatic tok_t enc_fp(input logic [W-1:0] v);
    tok_t t;
    for (int i = 0; i < W; i++) t[i] = v[i] ? 2'b10 : 2'b01;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tok_t cur_out(input bit sel);
    return sel ? ini_out : fp_out;
  endfunction

  task automatic set_ack(input bit sel, input logic v);
    if (sel) ini_ack_i = v;
    else     fp_ack_i  = v;
  endtask

  task automatic send_fp(input logic [W-1:0] v, input string tag);
    int n;
    fp_in = enc_fp(v);
    n = 0;
    while (!fp_ack_o && n < 20) begin tick(); n++; end
    check({tag, "_ack"}, 32'(fp_ack_o), 32'd1);
    fp_in = '0;
    n = 0;
    while (fp_ack_o && n < 20) begin tick(); n++; end
    check({tag, "_ackrel"}, 32'(fp_ack_o), 32'd0);
  endtask

  task automatic recv_fp(input bit sel, input logic [W-1:0] v, input string tag);
    int n;
    n = 0;
    while (cur_out(sel) == '0 && n < 20) begin tick(); n++; end
    check({tag, "_val"}, 32'(cur_out(sel)), 32'(enc_fp(v)));
    set_ack(sel, 1'b1);
    n = 0;
    while (cur_out(sel) != '0 && n < 20) begin tick(); n++; end
    check({tag, "_null"}, 32'(cur_out(sel)), 32'd0);
    set_ack(sel, 1'b0);
  endtask

  initial begin
    tok_t p;
    // FP reset state and single token 0xA5
    tick(); tick();
    check("fp_rst_ack", 32'(fp_ack_o), 32'd0);
    check("fp_rst_out", 32'(fp_out), 32'd0);
    check("fp_rst_level", 32'(fp_level), 32'd0);
    fp_rst = 1'b1;
    fp_in  = enc_fp(8'hA5);
    tick();
    check("fp1_ack_rise", 32'(fp_ack_o), 32'd1);
    check("fp1_level1", 32'(fp_level), 32'd1);
    check("fp1_out_still_null", 32'(fp_out), 32'd0);
    fp_in = '0;
    tick();
    check("fp1_out_tok", 32'(fp_out), 32'(enc_fp(8'hA5)));
    check("fp1_ack_fall", 32'(fp_ack_o), 32'd0);
    tick();
    fp_ack_i = 1'b1;
    tick();
    check("fp1_out_null", 32'(fp_out), 32'd0);
    check("fp1_level0", 32'(fp_level), 32'd0);
    fp_ack_i = 1'b0;
    tick();
    check("fp1_null_hold", 32'(fp_out), 32'd0);

    // FP fill: four accepted, fifth blocked until one pop
    send_fp(8'h01, "fill01");
    send_fp(8'h02, "fill02");
    send_fp(8'h03, "fill03");
    send_fp(8'h04, "fill04");
    fp_in = enc_fp(8'h05);
    repeat (5) tick();
    check("full_no_ack", 32'(fp_ack_o), 32'd0);
    check("full_level4", 32'(fp_level), 32'd4);
    check("full_head01", 32'(fp_out), 32'(enc_fp(8'h01)));
    fp_ack_i = 1'b1;
    tick();
    check("pop_full_no_push", 32'(fp_ack_o), 32'd0);
    check("pop_full_level3", 32'(fp_level), 32'd3);
    check("pop_full_out_null", 32'(fp_out), 32'd0);
    fp_ack_i = 1'b0;
    tick();
    check("fifth_ack", 32'(fp_ack_o), 32'd1);
    check("fifth_level4", 32'(fp_level), 32'd4);
    check("no_bubble_head02", 32'(fp_out), 32'(enc_fp(8'h02)));
    fp_in = '0;
    recv_fp(1'b0, 8'h02, "drain02");
    recv_fp(1'b0, 8'h03, "drain03");
    recv_fp(1'b0, 8'h04, "drain04");
    recv_fp(1'b0, 8'h05, "drain05");
    tick(); tick();
    check("drain_level0", 32'(fp_level), 32'd0);

    // FP partial word: bit 7 null for 10 cycles
    p    = enc_fp(8'h3C);
    p[7] = 2'b00;
    fp_in = p;
    repeat (10) tick();
    check("partial_no_ack", 32'(fp_ack_o), 32'd0);
    check("partial_level0", 32'(fp_level), 32'd0);
    fp_in = enc_fp(8'h3C);
    tick();
    check("partial_done_ack", 32'(fp_ack_o), 32'd1);
    check("partial_done_level", 32'(fp_level), 32'd1);
    fp_in = '0;
    recv_fp(1'b0, 8'h3C, "partial_tok");

    // Reset mid-operation with three tokens stored
    send_fp(8'h11, "mid11");
    send_fp(8'h22, "mid22");
    send_fp(8'h33, "mid33");
    tick();
    check("mid_level3", 32'(fp_level), 32'd3);
    fp_in    = enc_fp(8'h44);
    fp_ack_i = 1'b1;
    fp_rst   = 1'b0;
    tick();
    check("mid_rst_ack", 32'(fp_ack_o), 32'd0);
    check("mid_rst_out", 32'(fp_out), 32'd0);
    check("mid_rst_level", 32'(fp_level), 32'd0);
    fp_rst   = 1'b1;
    fp_in    = '0;
    fp_ack_i = 1'b0;
    tick();
    check("post_rst_level", 32'(fp_level), 32'd0);
    check("post_rst_out", 32'(fp_out), 32'd0);

`ifdef DR_TOKEN_FIFO_PROTO_CHECK_EN
    check("err_clear", 32'(fp_err), 32'd0);
    fp_in[0] = 2'b11;
    tick();
    check("err_set", 32'(fp_err), 32'd1);
    fp_in = '0;
    tick(); tick();
    check("err_sticky", 32'(fp_err), 32'd1);
    fp_rst = 1'b0;
    tick();
    check("err_rst", 32'(fp_err), 32'd0);
    fp_rst = 1'b1;
`endif

    // TP stream with random consumer delay
    check("tp_rst_out", 32'(tp_out), 32'd0);
    check("tp_rst_ack", 32'(tp_ack_o), 32'd0);
    tp_rst = 1'b1;
    fork
      begin : tp_source
        logic a0;
        int   n;
        for (int k = 0; k < 4; k++) begin
          a0    = tp_ack_o;
          tp_in = tp_in ^ enc_fp(tp_vals[k]);
          n = 0;
          while (tp_ack_o == a0 && n < 40) begin tick(); n++; end
          check("tp_ack_toggle", 32'(tp_ack_o != a0), 32'd1);
          if (tp_ack_o != a0) tp_toggles++;
        end
      end
      begin : tp_sink
        tok_t last;
        int   n;
        int   d;
        last = '0;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (tp_out == last && n < 40) begin tick(); n++; end
          check("tp_out_tok", 32'(tp_out), 32'(last ^ enc_fp(tp_vals[k])));
          last = tp_out;
          d = $urandom_range(0, 5);
          repeat (d) tick();
          tp_ack_i = ~tp_ack_i;
          tick();
        end
      end
    join
    repeat (3) tick();
    check("tp_toggles", 32'(tp_toggles), 32'd4);
    check("tp_level0", 32'(tp_level), 32'd0);

    // Pre-loaded tokens: N_INIT=2, INIT=0x5A
    check("ini_rst_level", 32'(ini_level), 32'd2);
    check("ini_rst_out", 32'(ini_out), 32'd0);
    ini_rst = 1'b1;
    tick();
    check("ini_first_out", 32'(ini_out), 32'(enc_fp(8'h5A)));
    check("ini_first_level", 32'(ini_level), 32'd2);
    recv_fp(1'b1, 8'h5A, "ini_tok0");
    recv_fp(1'b1, 8'h5A, "ini_tok1");
    repeat (3) tick();
    check("ini_empty_level", 32'(ini_level), 32'd0);
    check("ini_empty_out", 32'(ini_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
